// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory load controller.
//   e_imem_state : controller states
//   NOP_INSN     : RV32 "addi x0,x0,0", returned on faulting fetches and
//                  also used by decode as the canonical bubble.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    RESP
  } e_imem_state;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory load controller between the fetch unit and a
// req/gnt/rvalid memory bus. One word fetch outstanding at a time; the
// response comes back as a one-cycle rdy pulse with a registered insn/fault.
// Branch redirects (flush_i) drop in-flight data; misaligned or timed-out
// fetches return NOP_INSN with fault set.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   imem_load_en_i      fetch request strobe
//   imem_load_addr_i    byte address of the fetch
//   imem_load_busy_o    cannot accept a new request (state decode only)
//   imem_load_rdy_o     one-cycle response pulse
//   imem_load_insn_o    instruction word, valid with rdy
//   imem_load_fault_o   response is a fault (misaligned / timeout)
//   flush_i             branch redirect, discard outstanding response
//   mem_req_o/addr_o    bus request and word-aligned address
//   mem_gnt_i           bus grant
//   mem_rvalid_i/rdata_i bus read data
module imem_loader #(
  parameter int unsigned ADDRESS_WIDTH  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] NOP_INSN       = imem_loader_pkg::NOP_INSN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     imem_load_en_i,
  input  logic [ADDRESS_WIDTH-1:0] imem_load_addr_i,
  output logic                     imem_load_busy_o,
  output logic                     imem_load_rdy_o,
  output logic [31:0]              imem_load_insn_o,
  output logic                     imem_load_fault_o,
  input  logic                     flush_i,
  output logic                     mem_req_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [31:0]              mem_rdata_i
);
  import imem_loader_pkg::e_imem_state;
  import imem_loader_pkg::IDLE;
  import imem_loader_pkg::REQ;
  import imem_loader_pkg::WAIT;
  import imem_loader_pkg::DRAIN;
  import imem_loader_pkg::RESP;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  e_imem_state              state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]              insn_q, insn_d;
  logic                     fault_q, fault_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     drop_q, drop_d;   // flush seen while waiting for gnt

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    insn_d  = insn_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        // a request alongside a flush carries a stale PC
        if (imem_load_en_i && !flush_i) begin
          addr_d = {imem_load_addr_i[ADDRESS_WIDTH-1:2], 2'b00};
          drop_d = 1'b0;
          if (imem_load_addr_i[1:0] != 2'b00) begin
            state_d = RESP;
            insn_d  = NOP_INSN;
            fault_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          cnt_d = '0;
          if (drop_q || flush_i) begin
            // a zero-latency rvalid closes the dropped transaction at once
            state_d = mem_rvalid_i ? IDLE : DRAIN;
          end else if (mem_rvalid_i) begin
            state_d = RESP;
            insn_d  = mem_rdata_i;
            fault_d = 1'b0;
          end else begin
            state_d = WAIT;
          end
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (flush_i) begin
          state_d = mem_rvalid_i ? IDLE : DRAIN;
          cnt_d   = '0;
        end else if (mem_rvalid_i) begin
          state_d = RESP;
          insn_d  = mem_rdata_i;
          fault_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          insn_d  = NOP_INSN;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (mem_rvalid_i || cnt_q == CNT_LAST) state_d = IDLE;
        else                                   cnt_d   = cnt_q + CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      insn_q  <= NOP_INSN;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      insn_q  <= insn_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // busy covers RESP too so the fetch unit advances its PC first
  assign imem_load_busy_o  = (state_q != IDLE);
  assign imem_load_rdy_o   = (state_q == RESP) && !flush_i;
  assign imem_load_insn_o  = insn_q;
  assign imem_load_fault_o = fault_q;
  assign mem_req_o         = (state_q == REQ);
  assign mem_addr_o        = addr_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int AW = 64;
  localparam int T  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          busy, rdy, fault, req;
  logic [31:0]   insn;
  logic          flush = 1'b0;
  logic [AW-1:0] maddr;
  logic          gnt = 1'b0;
  logic          rvalid = 1'b0;
  logic [31:0]   rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  imem_loader #(.ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(T), .NOP_INSN(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_load_en_i(en), .imem_load_addr_i(addr),
    .imem_load_busy_o(busy), .imem_load_rdy_o(rdy),
    .imem_load_insn_o(insn), .imem_load_fault_o(fault),
    .flush_i(flush),
    .mem_req_o(req), .mem_addr_o(maddr),
    .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One fetch at cycle 0. Bus grants gw cycles after the first request
  // cycle; rvalid arrives rw cycles after the first wait cycle (rw = -1:
  // together with gnt). fc = cycle of a single-cycle flush, -1 for none.
  task automatic fetch(input string tag, input logic [AW-1:0] a, input int gw,
                       input int rw, input int fc, input logic [31:0] d);
    int gc, rvc, resp, exp_rdy, last, ncyc;
    int got_rdy, n_rdy, req_bad, busy_bad;
    logic acc, al, ef;
    logic [31:0] ei, got_insn;
    logic got_fault;

    // ---- expected behaviour from the protocol rules ----
    gc   = 1 + gw;
    rvc  = 2 + gw + rw;
    acc  = (fc != 0);
    al   = (a[1:0] == 2'b00);
    ei   = NOP;
    ef   = 1'b1;
    resp = -1;
    exp_rdy = -1;
    last = 0;
    if (!acc) begin
      last = 0;
    end else if (!al) begin
      resp = 1;
      last = 1;
      exp_rdy = (fc == 1) ? -1 : 1;
    end else begin
      if (rw <= T - 1) begin
        resp = rvc + 1; ei = d; ef = 1'b0;
      end else begin
        resp = 2 + gw + T;
      end
      if (fc >= 1 && fc <= gc)
        last = (rw < 0) ? gc : 2 + gw + imin(rw, T - 1);
      else if (fc > gc && fc < resp)
        last = (fc == rvc) ? fc : imin(rvc, fc + T);
      else
        last = resp;
      exp_rdy = (fc >= 1 && fc <= resp) ? -1 : resp;
    end
    ncyc = imax(imax(last, resp), imax(rvc, gc)) + 3;

    // ---- drive and observe ----
    got_rdy = -1; n_rdy = 0; req_bad = 0; busy_bad = 0;
    got_insn = '0; got_fault = 1'b0;
    chk({tag, ".idle_before"}, busy, 0);
    en = 1'b1; addr = a; flush = (fc == 0);
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      en = 1'b0; addr = $urandom;
      flush  = (c == fc);
      gnt    = (c == gc);
      rvalid = (c == rvc);
      rdata  = rvalid ? d : $urandom;
      #1;
      if (req !== (acc && al && c <= gc)) req_bad++;
      if (req === 1'b1 && maddr !== a) req_bad++;
      if (busy !== (c <= last)) busy_bad++;
      if (rdy === 1'b1) begin
        n_rdy++;
        if (got_rdy < 0) begin
          got_rdy = c; got_insn = insn; got_fault = fault;
        end
      end
    end
    tick();
    flush = 1'b0; gnt = 1'b0; rvalid = 1'b0;

    chk({tag, ".req"}, req_bad, 0);
    chk({tag, ".busy"}, busy_bad, 0);
    chk({tag, ".rdy_cycle"}, got_rdy, exp_rdy);
    chk({tag, ".rdy_count"}, n_rdy, (exp_rdy < 0) ? 0 : 1);
    if (exp_rdy >= 0) begin
      chk({tag, ".insn"}, got_insn, ei);
      chk({tag, ".fault"}, got_fault, ef);
    end
  endtask

  initial begin
    logic [AW-1:0] ra;
    int gw, rw, fc;

    // reset state
    repeat (3) tick();
    chk("rst.busy", busy, 0);
    chk("rst.rdy", rdy, 0);
    chk("rst.req", req, 0);
    chk("rst.insn", insn, NOP);
    chk("rst.fault", fault, 0);
    chk("rst.maddr", maddr, 0);
    rst_n = 1'b1;
    tick();

    // directed scenarios
    fetch("basic",      64'h40,  0, 2,     -1, 32'h00A0_0093);
    fetch("misalign",   64'h42,  0, 0,     -1, 32'h1234_5678);
    fetch("flush_wait", 64'h200, 0, 3,      2, 32'hDEAD_BEEF);
    fetch("after_drn",  64'h100, 0, 1,     -1, 32'h0040_0113);
    fetch("flush_en",   64'h80,  0, 1,      0, 32'h5555_AAAA);
    fetch("flush_resp", 64'h300, 0, 1,      4, 32'h0FF0_0FF0);
    fetch("timeout",    64'h400, 0, T + 1, -1, 32'hCAFE_F00D);
    fetch("zero_lat",   64'h440, 2, -1,    -1, 32'h0000_1337);
    fetch("flush_req",  64'h480, 3, 2,      2, 32'h7777_0000);

    // asynchronous reset in the middle of a request
    en = 1'b1; addr = 64'h500;
    tick();
    en = 1'b0;
    #1;
    chk("arst.req_before", req, 1);
    rst_n = 1'b0;
    #1;
    chk("arst.req", req, 0);
    chk("arst.busy", busy, 0);
    chk("arst.insn", insn, NOP);
    chk("arst.fault", fault, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // randomized fetches
    for (int i = 0; i < 60; i++) begin
      ra = {$urandom, $urandom};
      if ($urandom_range(3) != 0) ra[1:0] = 2'b00;
      gw = $urandom_range(3);
      rw = int'($urandom_range(T + 2)) - 1;
      fc = ($urandom_range(1) == 0) ? -1 : int'($urandom_range(15));
      fetch($sformatf("rnd%0d", i), ra, gw, rw, fc, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
